// File: rtl/lcd_timing.sv
// ---------------------------------------------------------------------------
// lcd_timing
//
// Free-running raster timing generator for the parallel RGB LCD path. It
// produces the pixel/line coordinates and the registered HSYNC/VSYNC/DEN
// strobes for the downstream pixel-fetch and colour stage.
//
// Axis order, both horizontally and vertically: sync, back porch, active
// area, front porch. Default parameters describe an 800x480 panel.
//
// Optional feature (compile-time macro LCD_TIMING_FRAME_CNT_EN):
//   adds an 8-bit frame counter output `frame_cnt` (reset value 8'hFF). It
//   steps on the same edge that raises frame_start, so the first frame after
//   reset reads 0. It wraps from 255 to 0.
//
// Ports:
//   pixel_clk    in   pixel clock, the only clock
//   rst          in   asynchronous reset, active low
//   x            out  horizontal counter, 0..H_TOTAL-1
//   y            out  vertical counter, 0..V_TOTAL-1
//   LCD_HYNC     out  horizontal sync, active level HS_POL
//   LCD_SYNC     out  vertical sync, active level VS_POL
//   LCD_DEN      out  data enable, high inside the visible area
//   line_start   out  one-cycle pulse while x==0
//   frame_start  out  one-cycle pulse while x==0 and y==0
//   frame_cnt    out  [LCD_TIMING_FRAME_CNT_EN only] frame counter
//
// Every output is a flop. The decodes are taken from the next-state counter
// values, so in any cycle the strobes describe the x/y shown in that cycle.
// ---------------------------------------------------------------------------
module lcd_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 210,
  parameter int H_SYNC   = 20,
  parameter int H_BACK   = 26,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 22,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 20,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        rst,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        LCD_HYNC,
  output logic        LCD_SYNC,
  output logic        LCD_DEN,
  output logic        line_start,
`ifdef LCD_TIMING_FRAME_CNT_EN
  output logic [7:0]  frame_cnt,
`endif
  output logic        frame_start
);

  // Derived raster geometry. All comparisons are unsigned 16-bit.
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [15:0] H_LAST    = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST    = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_SYNC_E  = 16'(H_SYNC);
  localparam logic [15:0] V_SYNC_E  = 16'(V_SYNC);
  localparam logic [15:0] H_START   = 16'(H_SYNC + H_BACK);
  localparam logic [15:0] V_START   = 16'(V_SYNC + V_BACK);
  localparam logic [15:0] H_END     = 16'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [15:0] V_END     = 16'(V_SYNC + V_BACK + V_ACTIVE);

  // -------------------------------------------------------------------------
  // Registered state
  // -------------------------------------------------------------------------
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_den;
  logic        r_line_start;
  logic        r_frame_start;

  // -------------------------------------------------------------------------
  // Next-state counters and decodes
  // -------------------------------------------------------------------------
  logic        w_x_wrap;
  logic        w_y_wrap;
  logic [15:0] w_x_nxt;
  logic [15:0] w_y_nxt;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_h_vis;
  logic        w_v_vis;
  logic        w_den_nxt;
  logic        w_ls_nxt;
  logic        w_fs_nxt;

  always_comb begin
    // Using >= rather than == makes the counters self-recover if a glitch
    // ever pushed them past the last position.
    w_x_wrap = (r_x >= H_LAST);
    w_y_wrap = (r_y >= V_LAST);

    w_x_nxt = w_x_wrap ? 16'd0 : (r_x + 16'd1);
    w_y_nxt = r_y;
    if (w_x_wrap) begin
      w_y_nxt = w_y_wrap ? 16'd0 : (r_y + 16'd1);
    end

    // Decodes look at the value the counters are about to take, so the
    // registered strobes line up with the registered coordinates.
    w_hs_act  = (w_x_nxt < H_SYNC_E);
    w_vs_act  = (w_y_nxt < V_SYNC_E);
    w_h_vis   = (w_x_nxt >= H_START) && (w_x_nxt < H_END);
    w_v_vis   = (w_y_nxt >= V_START) && (w_y_nxt < V_END);
    w_den_nxt = w_h_vis && w_v_vis;
    w_ls_nxt  = (w_x_nxt == 16'd0);
    w_fs_nxt  = w_ls_nxt && (w_y_nxt == 16'd0);
  end

  // -------------------------------------------------------------------------
  // Output registers. Reset parks the counters on the last position of the
  // frame so the first clock after release lands on x=0, y=0.
  // -------------------------------------------------------------------------
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      r_x           <= H_LAST;
      r_y           <= V_LAST;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_den         <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
      r_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
      r_den         <= w_den_nxt;
      r_line_start  <= w_ls_nxt;
      r_frame_start <= w_fs_nxt;
    end
  end

`ifdef LCD_TIMING_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  // Starts at 8'hFF so the increment on the first frame_start yields 0;
  // natural 8-bit overflow provides the 255 -> 0 wrap.
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= 8'hFF;
    end else if (w_fs_nxt) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign x           = r_x;
  assign y           = r_y;
  assign LCD_HYNC    = r_hsync;
  assign LCD_SYNC    = r_vsync;
  assign LCD_DEN     = r_den;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule
